// File: rtl/fetch_unit_pkg.sv
// Shared core package: fetch FSM state encoding, the canonical NOP word and
// the PC-stage opcodes used by the front end of the core.
//
// Contents:
//   fetch_state_e  - fetch unit FSM states (IDLE / REQ / WAIT / HOLD)
//   NOP_INSTR      - addi x0,x0,0, substituted for faulted instructions
//   pc_op_e        - operations requested from the PC stage
//   pcMisaligned   - helper that flags a PC that is not word aligned
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_OP_HOLD     = 2'd0,
    PC_OP_STEP     = 2'd1,
    PC_OP_REDIRECT = 2'd2
  } pc_op_e;

  // Instruction words are 4 bytes, so any set bit in pc[1:0] is misaligned.
  function automatic logic pcMisaligned(input logic [1:0] pcLow);
    return pcLow != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time for the
// current PC, holds the returned instruction toward decode and tells the PC
// stage when to step.
//
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   i_en                      - permission to start a new fetch
//   i_pc                      - current program counter from the PC stage
//   i_flush                   - one-cycle redirect pulse, kills in-flight work
//   o_imem_req_valid/_ready   - request handshake toward instruction memory
//   o_imem_addr               - request address
//   i_imem_rsp_valid/_data/_err - memory response
//   o_inst_valid/i_inst_ready - handshake toward decode
//   o_inst_data, o_inst_pc    - instruction word and its PC
//   o_inst_fault              - instruction faulted (data is then NOP)
//   o_pc_advance              - one-cycle pulse asking the PC stage to step
//
// Configuration:
//   FETCH_MISALIGN_CHECK_EN - when defined, a misaligned PC is not sent to
//   memory; it produces a faulted NOP directly.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_imem_rsp_err,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_fault,
  output logic            o_pc_advance
);

  localparam logic [XLEN-1:0] NopWord = XLEN'(NOP_INSTR);

  fetch_state_e    state_q, state_d;
  logic            first_q, first_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instData_q, instData_d;
  logic [XLEN-1:0] instPc_q, instPc_d;
  logic            fault_q, fault_d;
  logic            misaligned;
  logic            reqFire;

  // The PC is sampled during the first REQ cycle rather than on the edge that
  // enters REQ: after an accept the PC stage only updates on that same edge,
  // so the fresh value is visible one cycle after o_pc_advance. first_q marks
  // that cycle; afterwards the latched copy keeps the address stable.
`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (state_q == FETCH_REQ && first_q) begin
      misaligned = pcMisaligned(i_pc[1:0]);
    end
  end
`else
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      first_q    <= 1'b0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      instData_q <= NopWord;
      instPc_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      instData_q <= instData_d;
      instPc_q   <= instPc_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic. A flush during REQ/WAIT cannot withdraw the request, so
  // it only arms drop_q; the matching response is then swallowed. A flush in
  // HOLD beats a simultaneous decode accept.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    addr_d     = addr_q;
    instData_d = instData_q;
    instPc_d   = instPc_q;
    fault_d    = fault_q;
    reqFire    = 1'b0;

    if (state_q == FETCH_REQ && first_q) begin
      addr_d = i_pc;
    end

    case (state_q)
      FETCH_IDLE: begin
        if (i_en) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (misaligned) begin
          if (i_flush) begin
            state_d = FETCH_REQ;
          end else begin
            state_d    = FETCH_HOLD;
            instData_d = NopWord;
            instPc_d   = i_pc;
            fault_d    = 1'b1;
          end
        end else begin
          reqFire = i_imem_req_ready;
          drop_d  = drop_q | i_flush;
          if (reqFire) begin
            state_d = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        if (i_imem_rsp_valid) begin
          if (drop_q || i_flush) begin
            state_d = FETCH_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d    = FETCH_HOLD;
            instData_d = i_imem_rsp_err ? NopWord : i_imem_rsp_data;
            instPc_d   = addr_q;
            fault_d    = i_imem_rsp_err;
          end
        end else begin
          drop_d = drop_q | i_flush;
        end
      end
      FETCH_HOLD: begin
        if (i_flush) begin
          state_d = FETCH_REQ;
        end else if (i_inst_ready) begin
          state_d = i_en ? FETCH_REQ : FETCH_IDLE;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    // REQ->REQ self-loops (stalls, flushes while waiting) keep the latched PC.
    first_d = (state_d == FETCH_REQ) && (state_q != FETCH_REQ);
  end

  // Output logic.
  always_comb begin
    o_imem_req_valid = (state_q == FETCH_REQ) && !misaligned;
    o_imem_addr      = (state_q == FETCH_REQ && first_q) ? i_pc : addr_q;
    o_inst_valid     = (state_q == FETCH_HOLD);
    o_inst_data      = instData_q;
    o_inst_pc        = instPc_q;
    o_inst_fault     = fault_q;
    o_pc_advance     = (state_q == FETCH_HOLD) && i_inst_ready && !i_flush && !rst;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Inputs change on the falling edge and
// outputs are compared 1 time unit later, away from the rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        i_en;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst_data;
  logic [31:0] o_inst_pc;
  logic        o_inst_fault;
  logic        o_pc_advance;

  int testsRun  = 0;
  int failCount = 0;

  fetch_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_en             (i_en),
    .i_pc             (i_pc),
    .i_flush          (i_flush),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst_data      (o_inst_data),
    .o_inst_pc        (o_inst_pc),
    .o_inst_fault     (o_inst_fault),
    .o_pc_advance     (o_pc_advance)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle of stimulus: wait for the falling edge, drive, settle.
  task automatic applyStimulus(input logic en, input logic [31:0] pc,
                               input logic reqReady, input logic rspValid,
                               input logic [31:0] rspData, input logic rspErr,
                               input logic instReady, input logic flush);
    @(negedge clk);
    i_en             = en;
    i_pc             = pc;
    i_imem_req_ready = reqReady;
    i_imem_rsp_valid = rspValid;
    i_imem_rsp_data  = rspData;
    i_imem_rsp_err   = rspErr;
    i_inst_ready     = instReady;
    i_flush          = flush;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_en = 0; i_pc = 0; i_flush = 0; i_imem_req_ready = 0;
    i_imem_rsp_valid = 0; i_imem_rsp_data = 0; i_imem_rsp_err = 0; i_inst_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("rst_req_valid",  32'(o_imem_req_valid), 32'd0);
    checkOutput("rst_inst_valid", 32'(o_inst_valid), 32'd0);
    checkOutput("rst_pc_adv",     32'(o_pc_advance), 32'd0);
    checkOutput("rst_fault",      32'(o_inst_fault), 32'd0);
    checkOutput("rst_data",       o_inst_data, 32'h0000_0013);
    checkOutput("rst_addr",       o_imem_addr, 32'h0);
    checkOutput("rst_inst_pc",    o_inst_pc, 32'h0);

    // Back-to-back fetch with immediate ready and response
    applyStimulus(1, 32'h0, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("idle_no_req", 32'(o_imem_req_valid), 32'd0);
    applyStimulus(1, 32'h0, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("c1_req_valid", 32'(o_imem_req_valid), 32'd1);
    checkOutput("c1_addr", o_imem_addr, 32'h0);
    applyStimulus(1, 32'h0, 1, 1, 32'h0050_0093, 0, 0, 0);
    checkOutput("c2_inst_valid", 32'(o_inst_valid), 32'd0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 1, 0);
    checkOutput("c3_inst_valid", 32'(o_inst_valid), 32'd1);
    checkOutput("c3_data", o_inst_data, 32'h0050_0093);
    checkOutput("c3_pc", o_inst_pc, 32'h0);
    checkOutput("c3_pc_adv", 32'(o_pc_advance), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("after_accept_valid", 32'(o_inst_valid), 32'd0);
    checkOutput("after_accept_pc_adv", 32'(o_pc_advance), 32'd0);

    // Memory stalls 4 cycles; address must not follow a changing i_pc
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, (k == 0) ? 32'h40 : 32'h80, 0, 0, 32'h0, 0, 0, 0);
      checkOutput("stall_req_valid", 32'(o_imem_req_valid), 32'd1);
      checkOutput("stall_addr", o_imem_addr, 32'h40);
    end
    applyStimulus(1, 32'h80, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("stall_fire_addr", o_imem_addr, 32'h40);
    applyStimulus(1, 32'h80, 0, 1, 32'h1111_1111, 0, 0, 0);
    checkOutput("wait_no_second_req", 32'(o_imem_req_valid), 32'd0);

    // Decode stalls 5 cycles in HOLD
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 32'h80, 0, 0, 32'h0, 0, 0, 0);
      checkOutput("hold_valid", 32'(o_inst_valid), 32'd1);
      checkOutput("hold_data", o_inst_data, 32'h1111_1111);
      checkOutput("hold_pc", o_inst_pc, 32'h40);
      checkOutput("hold_no_adv", 32'(o_pc_advance), 32'd0);
    end
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 0, 1, 0);
    checkOutput("hold_accept_adv", 32'(o_pc_advance), 32'd1);
    // PC stage has stepped; the new request must carry the stepped PC
    applyStimulus(1, 32'h44, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("next_req_valid", 32'(o_imem_req_valid), 32'd1);
    checkOutput("next_req_addr", o_imem_addr, 32'h44);

    // Flush in WAIT; late response must be discarded
    applyStimulus(1, 32'h44, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("flush_wait_valid", 32'(o_inst_valid), 32'd0);
    applyStimulus(1, 32'h200, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("flush_wait_no_req", 32'(o_imem_req_valid), 32'd0);
    applyStimulus(1, 32'h200, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("late_rsp_valid", 32'(o_inst_valid), 32'd0);
    applyStimulus(1, 32'h200, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("refetch_req_valid", 32'(o_imem_req_valid), 32'd1);
    checkOutput("refetch_addr", o_imem_addr, 32'h200);
    checkOutput("refetch_inst_valid", 32'(o_inst_valid), 32'd0);
    applyStimulus(1, 32'h200, 0, 1, 32'h00A0_0113, 0, 0, 0);
    applyStimulus(1, 32'h200, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("refetch_hold_valid", 32'(o_inst_valid), 32'd1);
    checkOutput("refetch_data", o_inst_data, 32'h00A0_0113);
    checkOutput("refetch_pc", o_inst_pc, 32'h200);
    checkOutput("refetch_fault", 32'(o_inst_fault), 32'd0);
    applyStimulus(1, 32'h200, 0, 0, 32'h0, 0, 1, 0);
    checkOutput("refetch_adv", 32'(o_pc_advance), 32'd1);

    // Error response yields a faulted NOP
    applyStimulus(1, 32'h204, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("err_req_addr", o_imem_addr, 32'h204);
    applyStimulus(1, 32'h204, 0, 1, 32'h1234_5678, 1, 0, 0);
    applyStimulus(1, 32'h204, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("err_fault", 32'(o_inst_fault), 32'd1);
    checkOutput("err_data", o_inst_data, 32'h0000_0013);
    checkOutput("err_pc", o_inst_pc, 32'h204);

    // Flush coincident with decode accept: flush wins
    applyStimulus(1, 32'h204, 0, 0, 32'h0, 0, 1, 1);
    checkOutput("flush_accept_no_adv", 32'(o_pc_advance), 32'd0);
    applyStimulus(1, 32'h300, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("flush_hold_valid", 32'(o_inst_valid), 32'd0);
    checkOutput("flush_hold_req", 32'(o_imem_req_valid), 32'd1);
    checkOutput("flush_hold_addr", o_imem_addr, 32'h300);

    // Flush while the request is still waiting for ready
    applyStimulus(1, 32'h300, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("flush_req_valid", 32'(o_imem_req_valid), 32'd1);
    checkOutput("flush_req_addr", o_imem_addr, 32'h300);
    applyStimulus(1, 32'h400, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("flush_req_addr_stable", o_imem_addr, 32'h300);
    applyStimulus(1, 32'h400, 0, 1, 32'h0BAD_F00D, 0, 0, 0);
    applyStimulus(0, 32'h400, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("flush_req_discard", 32'(o_inst_valid), 32'd0);
    checkOutput("flush_req_newaddr", o_imem_addr, 32'h400);
    applyStimulus(0, 32'h400, 1, 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h400, 0, 1, 32'h0000_0033, 0, 0, 0);
    applyStimulus(0, 32'h400, 0, 0, 32'h0, 0, 1, 0);
    checkOutput("post_flush_data", o_inst_data, 32'h0000_0033);
    checkOutput("post_flush_adv", 32'(o_pc_advance), 32'd1);

    // Misaligned PC
    applyStimulus(1, 32'h102, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("mis_idle_valid", 32'(o_inst_valid), 32'd0);
    applyStimulus(1, 32'h102, 0, 0, 32'h0, 0, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("mis_no_req", 32'(o_imem_req_valid), 32'd0);
    applyStimulus(1, 32'h102, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("mis_valid", 32'(o_inst_valid), 32'd1);
    checkOutput("mis_fault", 32'(o_inst_fault), 32'd1);
    checkOutput("mis_pc", o_inst_pc, 32'h102);
    checkOutput("mis_data", o_inst_data, 32'h0000_0013);
    checkOutput("mis_mem_idle", 32'(o_imem_req_valid), 32'd0);
    applyStimulus(1, 32'h102, 0, 0, 32'h0, 0, 1, 0);
    checkOutput("mis_adv", 32'(o_pc_advance), 32'd1);
    applyStimulus(1, 32'h500, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("mis_next_addr", o_imem_addr, 32'h500);
`else
    checkOutput("mis_req", 32'(o_imem_req_valid), 32'd1);
    checkOutput("mis_addr", o_imem_addr, 32'h102);
    applyStimulus(1, 32'h102, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("mis_addr_fire", o_imem_addr, 32'h102);
`endif

    // Reset while a response is outstanding; a late response is ignored
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 1, 32'hCAFE_F00D, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_req", 32'(o_imem_req_valid), 32'd0);
    checkOutput("rst_mid_valid", 32'(o_inst_valid), 32'd0);
    checkOutput("rst_mid_data", o_inst_data, 32'h0000_0013);
    checkOutput("rst_mid_pc", o_inst_pc, 32'h0);
    checkOutput("rst_mid_fault", 32'(o_inst_fault), 32'd0);
    applyStimulus(0, 32'h0, 0, 1, 32'hCAFE_F00D, 0, 0, 0);
    checkOutput("rst_late_valid", 32'(o_inst_valid), 32'd0);
    checkOutput("rst_late_data", o_inst_data, 32'h0000_0013);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
